// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPllReset = 3'd1,
        StWaitLock = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } rst_state_e;

    function automatic int unsigned cnt_width(int unsigned pll_cycles, int unsigned timeout,
                                              int unsigned gap);
        int unsigned m;
        m = pll_cycles;
        if (timeout > m) m = timeout;
        if (gap > m) m = gap;
        return $clog2(m + 1);
    endfunction

    // Must hold MAX_RETRIES+1, the value latched when the sequencer gives up.
    function automatic int unsigned retry_width(int unsigned max_retries);
        return $clog2(max_retries + 2);
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Lock bus synchroniser plus consecutive-cycle filter; locked_ok once all locks held LOCK_FILTER
// cycles.
module lock_filter #(
    parameter int unsigned NUM_LOCKS   = 2,
    parameter int unsigned LOCK_FILTER = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LOCKS-1:0] lock_in,
    output logic [NUM_LOCKS-1:0] lock_sync,
    output logic                 locked_ok
);

    localparam int unsigned FiltW = $clog2(LOCK_FILTER + 1);
    localparam logic [FiltW-1:0] FiltMax = FiltW'(LOCK_FILTER);

    logic [NUM_LOCKS-1:0] meta_q;
    logic [NUM_LOCKS-1:0] sync_q;
    logic [FiltW-1:0]     filt_q;
    logic [FiltW-1:0]     filt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            filt_q <= '0;
        end else begin
            meta_q <= lock_in;
            sync_q <= meta_q;
            filt_q <= filt_d;
        end
    end

    always_comb begin
        filt_d = '0;
        if (&sync_q) begin
            filt_d = (filt_q == FiltMax) ? filt_q : filt_q + FiltW'(1);
        end
    end

    assign lock_sync = sync_q;
    assign locked_ok = (filt_q == FiltMax);

endmodule

// File: rtl/reset_sequencer.sv
// PLL reset and ordered domain-reset release on the oscillator clock, with retry and fault latch.
// Optional lock-loss statistics are built when RESET_SEQ_LOCK_STATS_EN is defined.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_LOCKS      = 2,
    parameter int unsigned NUM_RST        = 3,
    parameter int unsigned PLL_RST_CYCLES = 64,
    parameter int unsigned LOCK_FILTER    = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned RELEASE_GAP    = 256,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [NUM_LOCKS-1:0]                  lock_in,
    output logic                                  pll_rst,
    output logic [NUM_RST-1:0]                    rst_out,
    output logic                                  ready,
    output logic                                  fault,
    output logic [retry_width(MAX_RETRIES)-1:0]   retry_cnt,
    output logic [2:0]                            state_o,
    output logic [15:0]                           lock_loss_cnt,
    output logic [NUM_LOCKS-1:0]                  lock_loss_sticky
);

    localparam int unsigned CntW   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, RELEASE_GAP);
    localparam int unsigned RetryW = retry_width(MAX_RETRIES);
    localparam int unsigned IdxW   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [CntW-1:0]   PllLast     = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0]   GapLast     = CntW'(RELEASE_GAP - 1);
    localparam logic [IdxW-1:0]   RelLast     = IdxW'(NUM_RST - 1);
    localparam logic [RetryW-1:0] MaxRetry    = RetryW'(MAX_RETRIES);

    rst_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      rel_idx_q, rel_idx_d;
    logic [RetryW-1:0]    retry_q, retry_d;
    logic                 pll_rst_q, pll_rst_d;
    logic [NUM_RST-1:0]   rst_out_q, rst_out_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic                 en_meta_q, en_sync_q;
    logic [NUM_LOCKS-1:0] lock_sync;
    logic                 locked_ok;
    logic                 lock_lost;

    lock_filter #(
        .NUM_LOCKS   (NUM_LOCKS),
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk       (clk),
        .rst       (rst),
        .lock_in   (lock_in),
        .lock_sync (lock_sync),
        .locked_ok (locked_ok)
    );

    assign lock_lost = ~&lock_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_meta_q <= 1'b0;
            en_sync_q <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            rel_idx_q <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            en_meta_q <= enable;
            en_sync_q <= en_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rel_idx_q <= rel_idx_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
        rel_idx_d = rel_idx_q;
        retry_d   = retry_q;
        // Losing enable beats lock loss and timeout in the same cycle.
        if (!en_sync_q) begin
            state_d = StIdle;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StIdle:     state_d = StPllReset;
                StPllReset: if (cnt_q == PllLast) state_d = StWaitLock;
                StWaitLock: begin
                    if (locked_ok) begin
                        state_d = StRelease;
                    end else if (cnt_q == TimeoutLast) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = (retry_q >= MaxRetry) ? StFault : StPllReset;
                    end
                end
                StRelease: begin
                    if (lock_lost) begin
                        state_d = StPllReset;
                    end else if (rel_idx_q == RelLast) begin
                        state_d = StRun;
                    end else if (cnt_q == GapLast) begin
                        rel_idx_d = rel_idx_q + IdxW'(1);
                        cnt_d     = '0;
                    end
                end
                StRun:   if (lock_lost) state_d = StPllReset;
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
        if (state_d != state_q) begin
            cnt_d     = '0;
            rel_idx_d = '0;
        end
    end

    // Outputs decode the next state so they register in step with state_q.
    always_comb begin
        pll_rst_d = !(state_d inside {StWaitLock, StRelease, StRun});
        ready_d   = (state_d == StRun);
        fault_d   = (state_d == StFault);
        rst_out_d = '1;
        if (state_d == StRun) begin
            rst_out_d = '0;
        end else if (state_d == StRelease) begin
            for (int i = 0; i < int'(NUM_RST); i++) begin
                rst_out_d[i] = (i > int'(rel_idx_d));
            end
        end
    end

    assign pll_rst   = pll_rst_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign state_o   = state_q;

`ifdef RESET_SEQ_LOCK_STATS_EN
    logic [15:0]          loss_cnt_q;
    logic [NUM_LOCKS-1:0] sticky_q;
    logic                 loss_event;

    assign loss_event = en_sync_q && lock_lost && (state_q inside {StRelease, StRun});

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_q <= '0;
            sticky_q   <= '0;
        end else if (loss_event) begin
            loss_cnt_q <= (loss_cnt_q == 16'hFFFF) ? loss_cnt_q : loss_cnt_q + 16'd1;
            sticky_q   <= sticky_q | ~lock_sync;
        end
    end

    assign lock_loss_cnt    = loss_cnt_q;
    assign lock_loss_sticky = sticky_q;
`else
    assign lock_loss_cnt    = '0;
    assign lock_loss_sticky = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, corner sequences, randomized run vs model.
module tb_reset_sequencer;

    localparam int P = 4;
    localparam int F = 4;
    localparam int T = 100;
    localparam int G = 8;
    localparam int N = 3;
    localparam int M = 3;

    localparam int SIdle = 0, SPll = 1, SWait = 2, SRel = 3, SRun = 4, SFault = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  lock_in = 2'b00;
    logic        pll_rst;
    logic [2:0]  rst_out;
    logic        ready;
    logic        fault;
    logic [2:0]  retry_cnt;
    logic [2:0]  state_o;
    logic [15:0] lock_loss_cnt;
    logic [1:0]  lock_loss_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    bit chk_en  = 1'b0;

    reset_sequencer #(
        .NUM_LOCKS      (2),
        .NUM_RST        (N),
        .PLL_RST_CYCLES (P),
        .LOCK_FILTER    (F),
        .LOCK_TIMEOUT   (T),
        .RELEASE_GAP    (G),
        .MAX_RETRIES    (M)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .lock_in          (lock_in),
        .pll_rst          (pll_rst),
        .rst_out          (rst_out),
        .ready            (ready),
        .fault            (fault),
        .retry_cnt        (retry_cnt),
        .state_o          (state_o),
        .lock_loss_cnt    (lock_loss_cnt),
        .lock_loss_sticky (lock_loss_sticky)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus time-in-phase, inputs delayed through two sample stages.
    int         m_phase = SIdle;
    int         m_t = 0;
    int         m_retry = 0;
    int         m_filt = 0;
    bit         m_en1 = 0, m_en2 = 0;
    logic [1:0] m_lk1 = 0, m_lk2 = 0;
    int         m_loss = 0;
    logic [1:0] m_sticky = 0;

    task automatic model_step();
        int nxt;
        bit ok;
        if (rst) begin
            m_phase = SIdle; m_t = 0; m_retry = 0; m_filt = 0;
            m_en1 = 0; m_en2 = 0; m_lk1 = 0; m_lk2 = 0; m_loss = 0; m_sticky = 0;
            return;
        end
        ok  = (m_filt == F);
        nxt = m_phase;
        if (!m_en2) begin
            nxt = SIdle;
            m_retry = 0;
        end else begin
            case (m_phase)
                SIdle: nxt = SPll;
                SPll:  if (m_t + 1 == P) nxt = SWait;
                SWait: begin
                    if (ok) nxt = SRel;
                    else if (m_t + 1 == T) begin
                        m_retry++;
                        nxt = (m_retry > M) ? SFault : SPll;
                    end
                end
                SRel, SRun: begin
                    if (m_lk2 != 2'b11) begin
                        nxt = SPll;
`ifdef RESET_SEQ_LOCK_STATS_EN
                        if (m_loss < 65535) m_loss++;
                        m_sticky = m_sticky | ~m_lk2;
`endif
                    end else if (m_phase == SRel && m_t == (N - 1) * G) begin
                        nxt = SRun;
                    end
                end
                default: nxt = m_phase;
            endcase
        end
        m_t = (nxt != m_phase) ? 0 : m_t + 1;
        m_phase = nxt;
        m_filt = (m_lk2 == 2'b11) ? ((m_filt < F) ? m_filt + 1 : F) : 0;
        m_en2 = m_en1; m_en1 = enable;
        m_lk2 = m_lk1; m_lk1 = lock_in;
    endtask

    function automatic logic [2:0] exp_rst_out();
        logic [2:0] r;
        r = 3'b111;
        if (m_phase == SRun) r = 3'b000;
        else if (m_phase == SRel)
            for (int i = 0; i < N; i++) r[i] = !(i <= m_t / G);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [31:0] got, exp;
            got = {state_o, pll_rst, rst_out, ready, fault, retry_cnt, lock_loss_cnt, lock_loss_sticky};
            exp = {3'(m_phase), (m_phase != SWait && m_phase != SRel && m_phase != SRun),
                   exp_rst_out(), (m_phase == SRun), (m_phase == SFault), 3'(m_retry),
                   16'(m_loss), m_sticky};
            chk("model", got, exp);
        end
    end

    typedef struct {
        bit         en;
        logic [1:0] lock;
        int         n;
        logic [2:0] st;
        bit         pll;
        logic [2:0] ro;
        bit         rdy;
        bit         flt;
        logic [2:0] rc;
    } vec_t;

    vec_t tbl[14];

    task automatic wait_for(input string name, input int st, input int max_cyc);
        int k;
        k = 0;
        while (state_o !== 3'(st) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, {29'd0, state_o}, 32'(st));
    endtask

    initial begin
        bit seen_pll;
        tbl[0]  = '{1'b0, 2'b00, 5,  3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 2'b00, 3,  3'd1, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 2'b00, 4,  3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 2'b11, 10, 3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{1'b1, 2'b11, 8,  3'd3, 1'b0, 3'b100, 1'b0, 1'b0, 3'd0};
        tbl[5]  = '{1'b1, 2'b11, 8,  3'd4, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 2'b01, 3,  3'd1, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0};
        tbl[7]  = '{1'b1, 2'b11, 7,  3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 3'd0};
        tbl[8]  = '{1'b1, 2'b11, 17, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0};
        tbl[9]  = '{1'b1, 2'b01, 3,  3'd1, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b1, 2'b11, 7,  3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 3'd0};
        tbl[11] = '{1'b1, 2'b11, 17, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0};
        tbl[12] = '{1'b1, 2'b01, 3,  3'd1, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0};
        tbl[13] = '{1'b1, 2'b11, 24, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int v = 0; v < 14; v++) begin
            enable  = tbl[v].en;
            lock_in = tbl[v].lock;
            repeat (tbl[v].n) @(negedge clk);
            chk($sformatf("vec%0d", v),
                {20'd0, state_o, pll_rst, rst_out, ready, fault, retry_cnt},
                {20'd0, tbl[v].st, tbl[v].pll, tbl[v].ro, tbl[v].rdy, tbl[v].flt, tbl[v].rc});
        end

`ifdef RESET_SEQ_LOCK_STATS_EN
        chk("stats_cnt", {16'd0, lock_loss_cnt}, 32'd3);
        chk("stats_sticky", {30'd0, lock_loss_sticky}, 32'd2);
`else
        chk("stats_cnt", {16'd0, lock_loss_cnt}, 32'd0);
        chk("stats_sticky", {30'd0, lock_loss_sticky}, 32'd0);
`endif

        // Single-cycle drop of one lock while running.
        lock_in = 2'b01;
        @(negedge clk);
        lock_in = 2'b11;
        repeat (2) @(negedge clk);
        chk("drop1_rst_out", {29'd0, rst_out}, 32'h7);
        chk("drop1_state", {29'd0, state_o}, 32'(SPll));
        chk("drop1_retry", {29'd0, retry_cnt}, 32'd0);
        wait_for("drop1_rerun", SRun, 100);
        chk("drop1_ready", {31'd0, ready}, 32'd1);

        // Enable and lock lost together during release.
        lock_in = 2'b01;
        repeat (3) @(negedge clk);
        lock_in = 2'b11;
        wait_for("reach_release", SRel, 100);
        enable  = 1'b0;
        lock_in = 2'b00;
        repeat (3) @(negedge clk);
        chk("endrop_state", {29'd0, state_o}, 32'(SIdle));
        chk("endrop_rst_out", {29'd0, rst_out}, 32'h7);
        chk("endrop_retry", {29'd0, retry_cnt}, 32'd0);

        // Glitchy lock: filter never completes, retries exhaust.
        enable = 1'b1;
        for (int i = 0; i < 3000 && !fault; i++) begin
            lock_in = (i % 4 == 3) ? 2'b00 : 2'b11;
            @(negedge clk);
        end
        chk("glitch_fault", {31'd0, fault}, 32'd1);
        chk("glitch_retry", {29'd0, retry_cnt}, 32'd4);
        chk("glitch_state", {29'd0, state_o}, 32'(SFault));
        chk("glitch_pll_rst", {31'd0, pll_rst}, 32'd1);

        // Fault recovery through an enable drop.
        lock_in = 2'b11;
        enable  = 1'b0;
        repeat (5) @(negedge clk);
        chk("recover_fault", {31'd0, fault}, 32'd0);
        chk("recover_state", {29'd0, state_o}, 32'(SIdle));
        chk("recover_retry", {29'd0, retry_cnt}, 32'd0);
        enable = 1'b1;
        seen_pll = 1'b0;
        for (int i = 0; i < 200 && !ready; i++) begin
            @(negedge clk);
            if (state_o == 3'(SPll)) seen_pll = 1'b1;
        end
        chk("recover_pll_reset", {31'd0, seen_pll}, 32'd1);
        chk("recover_ready", {31'd0, ready}, 32'd1);

        // Randomized segments, checked cycle by cycle against the model.
        for (int s = 0; s < 60; s++) begin
            int len, mode;
            bit e;
            len  = $urandom_range(10, 150);
            mode = $urandom_range(0, 3);
            e    = ($urandom_range(0, 5) != 0);
            for (int c = 0; c < len; c++) begin
                rst    = ($urandom_range(0, 599) == 0);
                enable = e;
                case (mode)
                    0:       lock_in = 2'b11;
                    1:       lock_in = 2'($urandom_range(0, 3));
                    2:       lock_in = (c == len / 2) ? 2'($urandom_range(0, 2)) : 2'b11;
                    default: lock_in = (c % 4 == 3) ? 2'b00 : 2'b11;
                endcase
                @(negedge clk);
            end
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
